// File: rtl/ahb_req_arbiter_pkg.sv
// Shared AHB-Lite encodings, defaults and FSM state type for the request arbiter.
package ahb_req_arbiter_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // Data access, privileged, non-bufferable, non-cacheable.
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StLerr
   } state_e;

   // Sizes above a word, or addresses not aligned to the access size, are rejected locally.
   function automatic logic req_illegal(input logic [2:0] size, input logic [1:0] addr_lsb);
      return (size > HSIZE_WORD) ||
             ((size == HSIZE_HALF) && addr_lsb[0]) ||
             ((size == HSIZE_WORD) && (addr_lsb != 2'b00));
   endfunction

endpackage

// File: rtl/ahb_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner and favours the other on a tie.
module ahb_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic last_q;

   // One-hot grant; a lone requester always wins, a tie goes to the one not served last.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign gnt_id = gnt[1];

   // Track the last winner; reset value makes requester 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (|gnt) begin
         last_q <= gnt[1];
      end
   end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Two-requester front end onto a single AHB-Lite manager port, one transfer at a time.
module ahb_req_arbiter
   import ahb_req_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   // requester side
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_write,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [5:0]          req_size,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   // AHB-Lite manager side
   output logic                HSEL,
   output logic [ADDR_W-1:0]   HADDR,
   output logic [1:0]          HTRANS,
   output logic                HWRITE,
   output logic [2:0]          HSIZE,
   output logic [2:0]          HBURST,
   output logic [3:0]          HPROT,
   output logic [DATA_W-1:0]   HWDATA,
   input  logic                HREADY,
   input  logic [DATA_W-1:0]   HRDATA,
   input  logic                HRESP
);

   state_e              state_q;
   logic [1:0]          owner_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                arb_en;
   logic                gnt_id;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [2:0]          sel_size;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_bad;

   // Only single transfers with a fixed protection attribute are ever issued.
   assign HBURST = HBURST_SINGLE;
   assign HPROT  = HPROT_DEFAULT;

   // Arbitrate only in IDLE and never while reset is held, so req_ready stays low in reset.
   assign arb_en = HRESETn && (state_q == StIdle);

   ahb_rr_arb2 u_arb (
      .clk    (HCLK),
      .rst_n  (HRESETn),
      .en     (arb_en),
      .req    (req_valid),
      .gnt    (req_ready),
      .gnt_id (gnt_id)
   );

   // Steer the granted requester's fields and classify the request.
   always_comb begin
      sel_write = gnt_id ? req_write[1] : req_write[0];
      sel_addr  = gnt_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      sel_size  = gnt_id ? req_size[5:3] : req_size[2:0];
      sel_wdata = gnt_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      sel_bad   = req_illegal(sel_size, sel_addr[1:0]);
   end

   // Transfer FSM with registered bus and response outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= StIdle;
         owner_q   <= 2'b00;
         wdata_q   <= '0;
         HSEL      <= 1'b0;
         HTRANS    <= HTRANS_IDLE;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HSIZE     <= HSIZE_WORD;
         HWDATA    <= '0;
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         // Responses are single-cycle pulses.
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (|req_ready) begin
                  owner_q <= req_ready;
                  wdata_q <= sel_wdata;
                  if (sel_bad) begin
                     state_q   <= StLerr;
                     rsp_valid <= req_ready;
                     rsp_err   <= 1'b1;
                  end else begin
                     state_q <= StAddr;
                     HSEL    <= 1'b1;
                     HTRANS  <= HTRANS_NONSEQ;
                     HADDR   <= sel_addr;
                     HWRITE  <= sel_write;
                     HSIZE   <= sel_size;
                  end
               end
            end
            StAddr: begin
               if (HREADY) begin
                  state_q <= StData;
                  HSEL    <= 1'b0;
                  HTRANS  <= HTRANS_IDLE;
                  HWDATA  <= HWRITE ? wdata_q : '0;
               end
            end
            StData: begin
               // An HRESP=1 cycle with HREADY=0 is only the first half of an error response.
               if (HREADY) begin
                  state_q   <= StIdle;
                  HWDATA    <= '0;
                  rsp_valid <= owner_q;
                  rsp_err   <= HRESP;
                  rsp_rdata <= HWRITE ? '0 : HRDATA;
               end
            end
            StLerr: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
